// File: rtl/i2c_register_bank.sv
// Byte-addressed register file behind an I2C slave with an auto-incrementing register pointer.
// Define I2C_REGS_SHADOW_EN to stage writes in a shadow array that is committed on STOP.
module i2c_register_bank #(
  parameter int unsigned          REG_COUNT = 8,
  parameter logic [REG_COUNT-1:0] RO_MASK   = 'h01,
  parameter logic [7:0]           INIT_VAL  = 8'h00,
  localparam int unsigned         PTR_W     = $clog2(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i2c_start_stb,
  input  logic                   i2c_stop_stb,
  input  logic [7:0]             i2c_rx_data,
  input  logic                   i2c_rx_valid_stb,
  input  logic                   i2c_tx_done_stb,
  output logic [7:0]             i2c_tx_data,
  input  logic [7:0]             ro_data_in,
  output logic [8*REG_COUNT-1:0] regs_out,
  output logic                   wr_stb,
  output logic [PTR_W-1:0]       wr_addr
);

  typedef enum logic [1:0] {StIdle, StGetPtr, StWrData} state_e;

  // Read-only slots hold no data; they stay at zero in regs_out.
  function automatic logic [REG_COUNT-1:0][7:0] reset_image();
    logic [REG_COUNT-1:0][7:0] img;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      img[i] = RO_MASK[i] ? 8'h00 : INIT_VAL;
    end
    return img;
  endfunction

  localparam logic [REG_COUNT-1:0][7:0] REG_RST = reset_image();

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [REG_COUNT-1:0][7:0] regs_q, regs_d;
  logic [REG_COUNT-1:0][7:0] tx_src;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0]          wr_addr_q, wr_addr_d;
  logic                      wr_en;
  logic                      stop_evt;

  // Strobe priority: start > stop > rx_valid > tx_done; losers are dropped.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_en    = 1'b0;
    stop_evt = 1'b0;
    if (i2c_start_stb) begin
      state_d = StGetPtr;
    end else if (i2c_stop_stb) begin
      state_d  = StIdle;
      stop_evt = 1'b1;
    end else if (i2c_rx_valid_stb) begin
      case (state_q)
        StGetPtr: begin
          ptr_d   = i2c_rx_data[PTR_W-1:0];
          state_d = StWrData;
        end
        StWrData: begin
          wr_en = ~RO_MASK[ptr_q];
          ptr_d = ptr_q + PTR_W'(1);
        end
        default: ;
      endcase
    end else if (i2c_tx_done_stb) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

`ifdef I2C_REGS_SHADOW_EN
  logic [REG_COUNT-1:0][7:0] shadow_q, shadow_d;
  logic                      pending_q, pending_d;
  logic [PTR_W-1:0]          last_q, last_d;

  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    last_d    = last_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    if (wr_en) begin
      shadow_d[ptr_q] = i2c_rx_data;
      pending_d       = 1'b1;
      last_d          = ptr_q;
    end
    if (stop_evt) begin
      if (pending_q) begin
        regs_d    = shadow_q;
        wr_stb_d  = 1'b1;
        wr_addr_d = last_q;
      end
      pending_d = 1'b0;
    end
  end

  // The master reads back its own staged bytes before they are committed.
  assign tx_src = shadow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= REG_RST;
      pending_q <= 1'b0;
      last_q    <= '0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      last_q    <= last_d;
    end
  end
`else
  always_comb begin
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    if (wr_en) begin
      regs_d[ptr_q] = i2c_rx_data;
      wr_stb_d      = 1'b1;
      wr_addr_d     = ptr_q;
    end
  end

  assign tx_src = regs_d;
`endif

  // Built from next-state values so a new pointer or write shows up one cycle after its strobe.
  always_comb begin
    tx_data_d = RO_MASK[ptr_d] ? ro_data_in : tx_src[ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      regs_q    <= REG_RST;
      tx_data_q <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      regs_q    <= regs_d;
      tx_data_q <= tx_data_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign regs_out    = regs_q;
  assign i2c_tx_data = tx_data_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Bench for i2c_register_bank: directed scenarios plus random strobes against a behavioural model.
// Define I2C_REGS_SHADOW_EN here as well to check the shadow build.
module tb_i2c_register_bank;

  localparam int         N  = 8;
  localparam logic [7:0] RO = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i2c_start_stb = 1'b0;
  logic          i2c_stop_stb = 1'b0;
  logic [7:0]    i2c_rx_data = 8'h00;
  logic          i2c_rx_valid_stb = 1'b0;
  logic          i2c_tx_done_stb = 1'b0;
  logic [7:0]    i2c_tx_data;
  logic [7:0]    ro_data_in = 8'h00;
  logic [8*N-1:0] regs_out;
  logic          wr_stb;
  logic [2:0]    wr_addr;

  int n_checks = 0;
  int n_errors = 0;

  i2c_register_bank #(
    .REG_COUNT(N),
    .RO_MASK  (RO),
    .INIT_VAL (8'h00)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i2c_start_stb   (i2c_start_stb),
    .i2c_stop_stb    (i2c_stop_stb),
    .i2c_rx_data     (i2c_rx_data),
    .i2c_rx_valid_stb(i2c_rx_valid_stb),
    .i2c_tx_done_stb (i2c_tx_done_stb),
    .i2c_tx_data     (i2c_tx_data),
    .ro_data_in      (ro_data_in),
    .regs_out        (regs_out),
    .wr_stb          (wr_stb),
    .wr_addr         (wr_addr)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, pointer and transaction phase (0 idle, 1 pointer, 2 data).
  logic [7:0] m_regs   [N];
  logic [7:0] m_shadow [N];
  int         m_ptr;
  int         m_phase;
  bit         m_pend;
  int         m_last;
  logic [7:0] e_tx;
  logic       e_wr_stb;
  logic [2:0] e_wr_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_regs();
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i]   = 8'h00;
      m_shadow[i] = 8'h00;
    end
    m_ptr     = 0;
    m_phase   = 0;
    m_pend    = 1'b0;
    m_last    = 0;
    e_tx      = 8'h00;
    e_wr_stb  = 1'b0;
    e_wr_addr = 3'd0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic rv, input logic [7:0] rd,
                            input logic td, input logic [7:0] ro);
    e_wr_stb = 1'b0;
    if (s) begin
      m_phase = 1;
    end else if (p) begin
      m_phase = 0;
`ifdef I2C_REGS_SHADOW_EN
      if (m_pend) begin
        m_regs    = m_shadow;
        e_wr_stb  = 1'b1;
        e_wr_addr = 3'(m_last);
      end
      m_pend = 1'b0;
`endif
    end else if (rv) begin
      if (m_phase == 1) begin
        m_ptr   = rd % N;
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (!RO[m_ptr]) begin
`ifdef I2C_REGS_SHADOW_EN
          m_shadow[m_ptr] = rd;
          m_pend          = 1'b1;
          m_last          = m_ptr;
`else
          m_regs[m_ptr] = rd;
          e_wr_stb      = 1'b1;
          e_wr_addr     = 3'(m_ptr);
`endif
        end
        m_ptr = (m_ptr + 1) % N;
      end
    end else if (td) begin
      m_ptr = (m_ptr + 1) % N;
    end
`ifdef I2C_REGS_SHADOW_EN
    e_tx = RO[m_ptr] ? ro : m_shadow[m_ptr];
`else
    e_tx = RO[m_ptr] ? ro : m_regs[m_ptr];
`endif
  endtask

  task automatic compare_all();
    check("tx_data", i2c_tx_data, e_tx);
    check("regs_out", regs_out, exp_regs());
    check("wr_stb", wr_stb, e_wr_stb);
    check("wr_addr", wr_addr, e_wr_addr);
  endtask

  task automatic step(input logic s, input logic p, input logic rv, input logic [7:0] rd,
                      input logic td);
    logic [7:0] ro;
    i2c_start_stb    = s;
    i2c_stop_stb     = p;
    i2c_rx_valid_stb = rv;
    i2c_rx_data      = rd;
    i2c_tx_done_stb  = td;
    ro               = ro_data_in;
    @(posedge clk);
    #1;
    i2c_start_stb    = 1'b0;
    i2c_stop_stb     = 1'b0;
    i2c_rx_valid_stb = 1'b0;
    i2c_tx_done_stb  = 1'b0;
    model_step(s, p, rv, rd, td, ro);
    compare_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  task automatic start();       step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic stop();        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); endtask
  task automatic rx(input logic [7:0] d); step(1'b0, 1'b0, 1'b1, d, 1'b0); endtask
  task automatic tx_done();     step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); endtask
  task automatic idle();        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    apply_reset();
    check("t1_reset_regs", regs_out, 64'h0);
    check("t1_reset_tx", i2c_tx_data, 8'h00);

    // Write burst starting at register 3, then a stray byte while idle.
    start(); rx(8'h03); rx(8'hA5);
`ifndef I2C_REGS_SHADOW_EN
    check("t1_wr_addr3", wr_addr, 3'd3);
`endif
    rx(8'h5A); stop();
    check("t1_reg3", regs_out[31:24], 8'hA5);
    check("t1_reg4", regs_out[39:32], 8'h5A);
    rx(8'hEE);
    check("t1_idle_ignored", regs_out[47:40], 8'h00);

    // Set pointer then read back through a repeated START.
    start(); rx(8'h03); start();
    check("t2_read0", i2c_tx_data, 8'hA5);
    tx_done();
    check("t2_read1", i2c_tx_data, 8'h5A);
    tx_done();
    check("t2_read2", i2c_tx_data, 8'h00);
    stop();

    // Wrap from register 7 into the read-only register 0.
    ro_data_in = 8'hC3;
    start(); rx(8'h07); rx(8'h11);
    check("t3_ro_read", i2c_tx_data, 8'hC3);
    rx(8'h22);
    check("t3_ptr1", i2c_tx_data, 8'h00);
    stop();
    check("t3_reg7", regs_out[63:56], 8'h11);
    check("t3_reg0", regs_out[7:0], 8'h00);

    // Upper pointer bits ignored; START beats rx_valid in the same cycle.
    start(); rx(8'hFA); rx(8'h77); stop();
    check("t4_reg2", regs_out[23:16], 8'h77);
    start();
    step(1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
    rx(8'h04);
    check("t4_still_get_ptr", i2c_tx_data, 8'h5A);
    stop();

    // Reset in the middle of a burst.
    ro_data_in = 8'h3C;
    start(); rx(8'h05); rx(8'h99);
`ifndef I2C_REGS_SHADOW_EN
    idle();
    check("t5_reg5_written", regs_out[47:40], 8'h99);
`endif
    apply_reset();
    check("t5_regs_cleared", regs_out, 64'h0);
    idle();
    check("t5_ptr0", i2c_tx_data, 8'h3C);

`ifdef I2C_REGS_SHADOW_EN
    start(); rx(8'h02); rx(8'h42);
    check("t6_no_commit", regs_out, 64'h0);
    rx(8'h43);
    start(); rx(8'h02);
    check("t6_shadow_read", i2c_tx_data, 8'h42);
    stop();
    check("t6_reg2", regs_out[23:16], 8'h42);
    check("t6_reg3", regs_out[31:24], 8'h43);
    check("t6_commit_stb", wr_stb, 1'b1);
    check("t6_commit_addr", wr_addr, 3'd3);
    start(); stop();
    check("t6_empty", wr_stb, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ro_data_in = 8'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
             8'($urandom), $urandom_range(0, 4) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
